// File: rtl/uart_tx_fifo_pkg.sv
// Shared UART definitions: FSM state encodings, parity-mode selectors and the default bit period.
// The RX block imports the same package, so keep the encodings stable.
package uart_tx_fifo_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam int PAR_MODE_EVEN   = 0;
  localparam int PAR_MODE_ODD    = 1;
  localparam int DEFAULT_CLK_DIV = 16;

  // XOR of the low nbits of d, inverted for odd parity; bits above nbits are ignored.
  function automatic logic calc_parity(input logic [7:0] d, input int nbits, input logic odd);
    logic p;
    p = odd;
    for (int i = 0; i < 8; i++) begin
      if (i < nbits) p = p ^ d[i];
    end
    return p;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..CLK_DIV-1, ticks on the last count and wraps, so bits never drift.
// Synchronous clear holds it at zero while the line is idle.
module uart_baud_tick #(
  parameter int CLK_DIV = 16,
  parameter int CDW     = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  output logic tick_o
);

  logic [CDW-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == CDW'(CLK_DIV - 1));

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr_i || tick_o) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter draining a first-word-fall-through byte FIFO.
// Frame: start, DATA_BITS data LSB first, optional parity, STOP_BITS stop bits.
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int CLK_DIV    = DEFAULT_CLK_DIV,
  parameter int CDW        = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = PAR_MODE_EVEN,
  parameter int STOP_BITS  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] fifo_data,
  input  logic       fifo_empty,
  output logic       fifo_rd_en,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int            BIW       = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [BIW-1:0] LAST_BIT  = BIW'(DATA_BITS - 1);
  localparam logic          LAST_STOP = 1'(STOP_BITS - 1);
  localparam logic          ODD_SEL   = (PARITY_ODD == PAR_MODE_ODD);

  uart_state_e          state_q, state_d;
  logic [DATA_BITS-1:0] sreg_q, sreg_d;
  logic [BIW-1:0]       bit_q, bit_d;
  logic                 stop_q, stop_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 baud_tick;
  logic                 can_pop;
  logic                 pop;
  logic                 done_d;

  uart_baud_tick #(
    .CLK_DIV (CLK_DIV),
    .CDW     (CDW)
  ) u_baud (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (state_q == ST_IDLE),
    .tick_o (baud_tick)
  );

  // rst gates the pop so a non-empty FIFO is never drained while held in reset.
  assign can_pop = en & ~fifo_empty & ~rst;

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    bit_d   = bit_q;
    stop_d  = stop_q;
    par_d   = par_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (can_pop) pop = 1'b1;
      end
      ST_START: begin
        if (baud_tick) begin
          state_d = ST_DATA;
          bit_d   = '0;
          tx_d    = sreg_q[0];
          sreg_d  = sreg_q >> 1;
        end
      end
      ST_DATA: begin
        if (baud_tick) begin
          if (bit_q == LAST_BIT) begin
            if (PARITY_EN != 0) begin
              state_d = ST_PARITY;
              tx_d    = par_q;
            end else begin
              state_d = ST_STOP;
              stop_d  = 1'b0;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d  = bit_q + 1'b1;
            tx_d   = sreg_q[0];
            sreg_d = sreg_q >> 1;
          end
        end
      end
      ST_PARITY: begin
        if (baud_tick) begin
          state_d = ST_STOP;
          stop_d  = 1'b0;
          tx_d    = 1'b1;
        end
      end
      ST_STOP: begin
        if (baud_tick) begin
          if (stop_q == LAST_STOP) begin
            done_d = 1'b1;
            if (can_pop) begin
              pop = 1'b1;
            end else begin
              state_d = ST_IDLE;
              tx_d    = 1'b1;
            end
          end else begin
            stop_d = stop_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase

    // A pop from IDLE or from the last stop cycle both launch the start bit next cycle.
    if (pop) begin
      state_d = ST_START;
      sreg_d  = fifo_data[DATA_BITS-1:0];
      par_d   = calc_parity(fifo_data, DATA_BITS, ODD_SEL);
      tx_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sreg_q  <= '0;
      bit_q   <= '0;
      stop_q  <= 1'b0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
    end
  end

  assign fifo_rd_en = pop;
  assign tx         = tx_q;
  assign busy       = (state_q != ST_IDLE);
  assign done       = done_d;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench: four transmitter configurations, each fed by a small FIFO model.
// Instance 0: div 4 / no parity / 1 stop; 1: even parity; 2: odd parity; 3: div 7 / 2 stop.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] en;
  logic [3:0] rd, tx, busy, done;
  logic [7:0] fmem [4][64];
  int         wp   [4];
  int         rp   [4];
  int         npop [4];
  int         n_assert = 0;
  int         n_fail   = 0;

  logic [7:0] rx_bytes [$];
  int         rx_err = 0;
  logic [7:0] sent [16];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    uart_tx_fifo #(
      .DATA_BITS  (8),
      .CLK_DIV    ((g == 3) ? 7 : 4),
      .CDW        (8),
      .PARITY_EN  ((g == 1 || g == 2) ? 1 : 0),
      .PARITY_ODD ((g == 2) ? 1 : 0),
      .STOP_BITS  ((g == 3) ? 2 : 1)
    ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en[g]),
      .fifo_data  (fmem[g][rp[g] % 64]),
      .fifo_empty (wp[g] == rp[g]),
      .fifo_rd_en (rd[g]),
      .tx         (tx[g]),
      .busy       (busy[g]),
      .done       (done[g])
    );
  end

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rd[i]) begin
        rp[i]   <= rp[i] + 1;
        npop[i] <= npop[i] + 1;
      end
    end
  end

  // Mid-bit sampling decoder for instance 3 (7 clocks per bit, 2 stop bits).
  initial begin : mon_p
    logic [7:0] b;
    logic       ok;
    b  = '0;
    ok = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst && tx[3] === 1'b0) begin
        repeat (3) @(negedge clk);
        ok = (tx[3] === 1'b0);
        for (int j = 0; j < 8; j++) begin
          repeat (7) @(negedge clk);
          b[j] = tx[3];
        end
        for (int j = 0; j < 2; j++) begin
          repeat (7) @(negedge clk);
          if (tx[3] !== 1'b1) ok = 1'b0;
        end
        if (!ok) rx_err++;
        rx_bytes.push_back(b);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int i, input logic [7:0] b);
    fmem[i][wp[i] % 64] = b;
    wp[i] = wp[i] + 1;
  endtask

  // Call just after a posedge; returns at the negedge of the pop cycle.
  task automatic wait_pop(input int i, input string tag);
    int c;
    c = 0;
    @(negedge clk);
    while (!rd[i] && c < 300) begin
      @(negedge clk);
      c++;
    end
    chk(tag, 32'(rd[i]), 32'd1);
  endtask

  // Checks {rd, done, busy, tx} on every cycle T+1..T+N*div after the pop cycle T.
  task automatic frame_check(input int i, input logic [7:0] d, input int div, input int pen,
                             input logic podd, input int nstop, input int drop_k,
                             input logic rd_last, input string tag);
    int         tot, b;
    logic       etx;
    logic [3:0] e;
    tot = (1 + 8 + pen + nstop) * div;
    for (int k = 1; k <= tot; k++) begin
      @(negedge clk);
      b = (k - 1) / div;
      if (b == 0)                     etx = 1'b0;
      else if (b <= 8)                etx = d[b-1];
      else if (pen != 0 && b == 9)    etx = (^d) ^ podd;
      else                            etx = 1'b1;
      e = {(k == tot) ? rd_last : 1'b0, (k == tot), 1'b1, etx};
      chk($sformatf("%s k=%0d {rd,done,busy,tx}", tag, k), 32'({rd[i], done[i], busy[i], tx[i]}), 32'(e));
      if (k == drop_k) en[i] = 1'b0;
    end
  endtask

  initial begin
    int c;
    en = '0;
    #1 rst = 1'b1;

    // Reset with a byte queued and en high: no pop may leak out.
    push(0, 8'hA5);
    en[0] = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_rd_en", 32'(rd[0]), 32'd0);
    chk("rst_tx_busy_done", 32'({tx[0], busy[0], done[0]}), 32'b100);
    en[0] = 1'b0;
    step();
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("idle_no_pop_en0", 32'(npop[0]), 32'd0);

    // Single byte 0xA5.
    step();
    en[0] = 1'b1;
    wait_pop(0, "t2_pop");
    frame_check(0, 8'hA5, 4, 0, 1'b0, 1, 0, 1'b0, "t2");
    @(negedge clk);
    chk("t2_idle_busy_tx", 32'({busy[0], tx[0]}), 32'b01);
    chk("t2_pops", 32'(npop[0]), 32'd1);
    chk("t2_fifo_empty", 32'(wp[0] - rp[0]), 32'd0);

    // Back-to-back 0x00, 0xFF.
    step();
    push(0, 8'h00);
    push(0, 8'hFF);
    wait_pop(0, "t3_pop1");
    frame_check(0, 8'h00, 4, 0, 1'b0, 1, 0, 1'b1, "t3a");
    frame_check(0, 8'hFF, 4, 0, 1'b0, 1, 0, 1'b0, "t3b");
    chk("t3_pops", 32'(npop[0]), 32'd3);

    // Reset mid-frame drops the byte; nothing pops while en is low afterwards.
    step();
    push(0, 8'h3C);
    wait_pop(0, "t1_pop");
    repeat (10) @(negedge clk);
    step();
    rst   = 1'b1;
    en[0] = 1'b0;
    #1;
    chk("t1_async_tx_busy_done", 32'({tx[0], busy[0], done[0]}), 32'b100);
    push(0, 8'hC3);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (60) @(negedge clk);
    chk("t1_no_pop_after_rst", 32'(npop[0]), 32'd4);
    chk("t1_idle_tx_busy", 32'({tx[0], busy[0]}), 32'b10);
    step();
    en[0] = 1'b1;
    wait_pop(0, "t1_pop_next");
    frame_check(0, 8'hC3, 4, 0, 1'b0, 1, 0, 1'b0, "t1_next");

    // en dropped during data bit 3 with two bytes still queued.
    step();
    push(0, 8'h81);
    push(0, 8'h42);
    push(0, 8'h99);
    wait_pop(0, "t5_pop1");
    frame_check(0, 8'h81, 4, 0, 1'b0, 1, 17, 1'b0, "t5a");
    @(negedge clk);
    chk("t5_idle_busy_tx", 32'({busy[0], tx[0]}), 32'b01);
    repeat (30) @(negedge clk);
    chk("t5_no_pop_en0", 32'(npop[0]), 32'd6);
    step();
    en[0] = 1'b1;
    wait_pop(0, "t5_pop2");
    frame_check(0, 8'h42, 4, 0, 1'b0, 1, 0, 1'b1, "t5b");
    frame_check(0, 8'h99, 4, 0, 1'b0, 1, 0, 1'b0, "t5c");
    chk("t5_pops", 32'(npop[0]), 32'd8);

    // Parity: even on instance 1, odd on instance 2.
    step();
    en[1] = 1'b1;
    push(1, 8'hA5);
    push(1, 8'h07);
    wait_pop(1, "t4_pop_even");
    frame_check(1, 8'hA5, 4, 1, 1'b0, 1, 0, 1'b1, "t4_even_a5");
    frame_check(1, 8'h07, 4, 1, 1'b0, 1, 0, 1'b0, "t4_even_07");
    step();
    en[2] = 1'b1;
    push(2, 8'hA5);
    wait_pop(2, "t4_pop_odd");
    frame_check(2, 8'hA5, 4, 1, 1'b1, 1, 0, 1'b0, "t4_odd_a5");

    // Two stop bits, 7 clocks per bit, 16 random bytes.
    for (int j = 0; j < 16; j++) sent[j] = 8'($urandom_range(0, 255));
    step();
    en[3] = 1'b1;
    for (int j = 0; j < 16; j++) push(3, sent[j]);
    wait_pop(3, "t6_pop1");
    frame_check(3, sent[0], 7, 0, 1'b0, 2, 0, 1'b1, "t6_first");
    c = 0;
    while (!(npop[3] == 16 && !busy[3]) && c < 1400) begin
      @(negedge clk);
      c++;
    end
    chk("t6_all_sent_idle", 32'({npop[3] == 16, busy[3]}), 32'b10);
    repeat (5) @(negedge clk);
    chk("t6_rx_count", 32'(rx_bytes.size()), 32'd16);
    for (int j = 0; j < 16; j++) begin
      if (j < rx_bytes.size()) chk($sformatf("t6_rx_byte%0d", j), 32'(rx_bytes[j]), 32'(sent[j]));
    end
    chk("t6_rx_frame_errors", 32'(rx_err), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
